// File: rtl/gate_preact_mac.sv
// LSTM gate pre-activation MAC: y = sum(w[k]*x[k]) + bias, rounded and saturated
// to the D_WL/D_FL format. Pipeline: multiply, accumulate, round/saturate.
module gate_preact_mac #(
    parameter int D_WL   = 16,
    parameter int D_FL   = 12,
    parameter int ACC_WL = 40,
    parameter int N_MAX  = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            in_last,
    input  logic [D_WL-1:0] w,
    input  logic [D_WL-1:0] x,
    input  logic [D_WL-1:0] bias,
    output logic [D_WL-1:0] d_o,
    output logic            o_valid,
    output logic            sat,
    output logic            len_err
);

    localparam int CNT_W = $clog2(N_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_MAX);

    localparam logic signed [ACC_WL-1:0] RND_HALF = {{(ACC_WL-1){1'b0}}, 1'b1} << (D_FL - 1);
    localparam logic signed [ACC_WL-1:0] Y_MAX    = {{(ACC_WL-D_WL+1){1'b0}}, {(D_WL-1){1'b1}}};
    localparam logic signed [ACC_WL-1:0] Y_MIN    = {{(ACC_WL-D_WL+1){1'b1}}, {(D_WL-1){1'b0}}};

    logic signed [2*D_WL-1:0] p;
    logic                     v1;
    logic                     l1;
    logic        [D_WL-1:0]   b1;
    logic signed [ACC_WL-1:0] acc;
    logic signed [ACC_WL-1:0] fin;
    logic                     v2;
    logic signed [ACC_WL-1:0] p_ext;
    logic signed [ACC_WL-1:0] b_ext;
    logic signed [ACC_WL-1:0] rnd;
    logic        [CNT_W-1:0]  cnt;

    // Product carries 2*D_FL fraction bits, so the bias is aligned by D_FL.
    assign p_ext = {{(ACC_WL-2*D_WL){p[2*D_WL-1]}}, p};
    assign b_ext = {{(ACC_WL-D_WL){b1[D_WL-1]}}, b1} << D_FL;
    assign rnd   = (fin + RND_HALF) >>> D_FL;

    // S1 control: valids clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            l1 <= 1'b0;
        end else begin
            v1 <= in_valid;
            l1 <= in_valid & in_last;
        end
    end

    // NOTE: pure datapath registers carry no reset; they are only consumed when
    // a reset-cleared valid qualifies them, so resetting them buys nothing.
    always_ff @(posedge clk) begin
        p <= $signed(w) * $signed(x);
        if (in_valid && in_last)
            b1 <= bias;
        if (v1 && l1)
            fin <= acc + p_ext + b_ext;
    end

    // S2: accumulator clears on the last element so the next vector can follow directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            v2  <= 1'b0;
        end else begin
            v2 <= v1 & l1;
            if (v1) begin
                if (l1)
                    acc <= '0;
                else
                    acc <= acc + p_ext;
            end
        end
    end

    // S3: round-half-up already applied in rnd; clamp to the output range.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_o     <= '0;
            o_valid <= 1'b0;
            sat     <= 1'b0;
        end else begin
            o_valid <= v2;
            sat     <= 1'b0;
            if (v2) begin
                if (rnd > Y_MAX) begin
                    d_o <= {1'b0, {(D_WL-1){1'b1}}};
                    sat <= 1'b1;
                end else if (rnd < Y_MIN) begin
                    d_o <= {1'b1, {(D_WL-1){1'b0}}};
                    sat <= 1'b1;
                end else begin
                    d_o <= rnd[D_WL-1:0];
                end
            end
        end
    end

    // Element counter saturates at N_MAX; len_err is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            len_err <= 1'b0;
        end else if (in_valid) begin
            if (cnt == CNT_MAX)
                len_err <= 1'b1;
            if (in_last)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_gate_preact_mac.sv
// Scoreboard bench for gate_preact_mac: the driver pushes expected results computed
// with plain integer arithmetic; a negedge monitor pops and compares on o_valid.
module tb_gate_preact_mac;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] w = '0;
    logic [15:0] x = '0;
    logic [15:0] bias = '0;
    logic [15:0] d_o;
    logic        o_valid;
    logic        sat;
    logic        len_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] d;
        logic        s;
        int          c;
    } exp_t;

    exp_t        sb[$];
    shortint     cur_w[$];
    shortint     cur_x[$];
    logic [15:0] last_d = '0;

    gate_preact_mac dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_last (in_last),
        .w       (w),
        .x       (x),
        .bias    (bias),
        .d_o     (d_o),
        .o_valid (o_valid),
        .sat     (sat),
        .len_err (len_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Real-valued sum of products plus bias, in units of 2^-24, then round and clamp.
    function automatic exp_t model(input logic [15:0] b, input int c);
        longint s;
        longint r;
        exp_t   e;
        s = longint'($signed(b)) * 4096;
        foreach (cur_w[i]) s += longint'(cur_w[i]) * longint'(cur_x[i]);
        r = (s + 2048) >>> 12;
        e.c = c;
        if (r > 32767) begin
            e.d = 16'h7FFF;
            e.s = 1'b1;
        end else if (r < -32768) begin
            e.d = 16'h8000;
            e.s = 1'b1;
        end else begin
            e.d = 16'(r);
            e.s = 1'b0;
        end
        return e;
    endfunction

    task automatic elem(input logic [15:0] wv, input logic [15:0] xv, input logic last,
                        input logic [15:0] bv);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_last  = last;
        w        = wv;
        x        = xv;
        bias     = last ? bv : 16'($urandom);
        cur_w.push_back(shortint'(wv));
        cur_x.push_back(shortint'(xv));
        if (last) begin
            sb.push_back(model(bv, cyc + 3));
            cur_w.delete();
            cur_x.delete();
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'($urandom);
        w        = 16'($urandom);
        x        = 16'($urandom);
        bias     = 16'($urandom);
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 20) begin
            idle();
            k++;
        end
        idle();
        check("drain_pending", longint'(sb.size()), 0);
    endtask

    function automatic logic [15:0] rand_val(input bit wide);
        if (wide)
            return 16'($urandom);
        return 16'($urandom_range(0, 16'h3FFF) - 32'h2000);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            last_d = '0;
        end else if (o_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_o_valid: got d_o=%h required no output (cycle %0d)", d_o, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("d_o", longint'(d_o), longint'(e.d));
                check("sat", longint'(sat), longint'(e.s));
                check("latency", longint'(cyc), longint'(e.c));
                last_d = d_o;
            end
        end else begin
            check("d_o_hold", longint'(d_o), longint'(last_d));
            check("sat_idle", longint'(sat), 0);
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_d_o", longint'(d_o), 0);
        check("reset_o_valid", longint'(o_valid), 0);
        check("reset_sat", longint'(sat), 0);
        check("reset_len_err", longint'(len_err), 0);

        // Basic 4-element sum.
        for (int i = 0; i < 4; i++) elem(16'h1000, 16'h1000, i == 3, 16'h0000);
        drain();
        // Negative with bias.
        for (int i = 0; i < 3; i++) elem(16'h1000, 16'hF000, i == 2, 16'h0800);
        drain();
        // Rounding at the half boundary.
        elem(16'h0001, 16'h0800, 1'b1, 16'h0000);
        elem(16'h0001, 16'h07FF, 1'b1, 16'h0000);
        drain();
        // Positive and negative saturation.
        for (int i = 0; i < 8; i++) elem(16'h1000, 16'h4000, i == 7, 16'h0000);
        for (int i = 0; i < 8; i++) elem(16'h1000, 16'hC000, i == 7, 16'h0000);
        drain();
        // Back-to-back vectors with an idle cycle inside the second.
        elem(16'h1000, 16'h1000, 1'b0, 16'h0000);
        elem(16'h1000, 16'h1000, 1'b1, 16'h0000);
        elem(16'h0800, 16'h1000, 1'b0, 16'h0000);
        idle();
        elem(16'h0800, 16'h1000, 1'b1, 16'h0000);
        drain();

        // Reset mid-vector discards the partial sum.
        elem(16'h1000, 16'h1000, 1'b0, 16'h0000);
        elem(16'h1000, 16'h1000, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        cur_w.delete();
        cur_x.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        elem(16'h1000, 16'h1000, 1'b1, 16'h0000);
        drain();

        // Randomized back-to-back vectors with random gaps.
        for (int v = 0; v < 80; v++) begin
            int          n;
            bit          wide;
            logic [15:0] b;
            n    = $urandom_range(1, 8);
            wide = 1'($urandom);
            b    = rand_val(wide);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) idle();
                elem(rand_val(wide), rand_val(wide), k == n - 1, b);
            end
        end
        drain();
        check("len_err_idle", longint'(len_err), 0);

        // Length error: N_MAX non-last elements is still fine, one more sets len_err.
        for (int i = 0; i < 256; i++) elem(16'h0010, 16'h0010, 1'b0, 16'h0000);
        idle();
        check("len_err_at_n_max", longint'(len_err), 0);
        elem(16'h0010, 16'h0010, 1'b0, 16'h0000);
        idle();
        check("len_err_set", longint'(len_err), 1);
        elem(16'h0010, 16'h0010, 1'b1, 16'h0000);
        drain();
        repeat (5) idle();
        check("len_err_sticky", longint'(len_err), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("len_err_after_rst", longint'(len_err), 0);
        repeat (3) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
